freq_gate_sequencer: RTL and testbench

Measurement sequencer for the frequency meter: the initiator side of the settle/relax handshake.
- On start, raises relaxEn to the relax/settle delay generator and waits for its relaxIn level.
- Then opens a fixed-length gate and counts rising edges of the asynchronous measured signal.
- Presents the count on a valid/ready output and drops relaxEn so the delay generator re-arms.

---
 rtl/freq_gate_sequencer_if.sv | 26 ++
 rtl/freq_gate_sequencer.sv | 135 +++++++++++++
 tb/tb_freq_gate_sequencer.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/freq_gate_sequencer_if.sv
// Handshake and measurement signals between the gate sequencer (master) and its environment:
// start request, relax/settle delay generator, measured signal and result consumer.
interface freq_gate_sequencer_if #(
  parameter int unsigned COUNT_W = 32
) ();
  logic               start;
  logic               sigIn;
  logic               relaxIn;
  logic               relaxEn;
  logic               busy;
  logic [COUNT_W-1:0] result;
  logic               resultValid;
  logic               resultReady;
  logic               overflow;
  logic               timeoutErr;

  modport master (
    input  start, sigIn, relaxIn, resultReady,
    output relaxEn, busy, result, resultValid, overflow, timeoutErr
  );

  modport slave (
    output start, sigIn, relaxIn, resultReady,
    input  relaxEn, busy, result, resultValid, overflow, timeoutErr
  );
endinterface

// File: rtl/freq_gate_sequencer.sv
// Frequency-meter sequencer: requests settle from the delay generator, counts rising edges of
// an asynchronous signal over a fixed gate, then offers the count on a valid/ready output.
module freq_gate_sequencer #(
  parameter int unsigned GATE_CYCLES    = 5000000,
  parameter int unsigned TIMEOUT_CYCLES = 10000000,
  parameter int unsigned COUNT_W        = 32
) (
  input logic                   sysClk,
  input logic                   sysRst_n,
  freq_gate_sequencer_if.master bus
);

  localparam logic [31:0] GateLast    = 32'(GATE_CYCLES - 1);
  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StGate, StDone} stateE;

  stateE              stateQ, stateD;
  logic               sync1Q, sync2Q, sync3Q;
  logic [31:0]        waitCntQ;
  logic [31:0]        gateCntQ;
  logic [COUNT_W-1:0] edgeCntQ;
  logic [COUNT_W-1:0] resultQ;
  logic               overflowQ;
  logic               timeoutErrQ;

  logic               sigEdge;
  logic               waitDone;
  logic               gateDone;
  logic               cntAtMax;
  logic               satHit;
  logic [COUNT_W-1:0] edgeCntNext;

  assign sigEdge  = sync2Q & ~sync3Q;
  assign waitDone = (waitCntQ == TimeoutLast);
  assign gateDone = (gateCntQ == GateLast);
  assign cntAtMax = &edgeCntQ;
  // An edge arriving at full scale is dropped and flagged rather than wrapping.
  assign satHit      = sigEdge & cntAtMax;
  assign edgeCntNext = (sigEdge && !cntAtMax) ? edgeCntQ + 1'b1 : edgeCntQ;

  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle: begin
        if (bus.start) stateD = StSettle;
      end
      StSettle: begin
        if (bus.relaxIn) begin
          stateD = StGate;
        end else if (waitDone) begin
          stateD = StIdle;
        end
      end
      StGate: begin
        if (gateDone) stateD = StDone;
      end
      StDone: begin
        if (bus.resultReady) stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  always_comb begin
    bus.relaxEn     = 1'b0;
    bus.busy        = 1'b1;
    bus.resultValid = 1'b0;
    unique case (stateQ)
      StIdle:   bus.busy        = 1'b0;
      StSettle: bus.relaxEn     = 1'b1;
      StGate:   bus.relaxEn     = 1'b1;
      StDone:   bus.resultValid = 1'b1;
      default:  bus.busy        = 1'b0;
    endcase
  end

  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      sync1Q      <= 1'b0;
      sync2Q      <= 1'b0;
      sync3Q      <= 1'b0;
      waitCntQ    <= '0;
      gateCntQ    <= '0;
      edgeCntQ    <= '0;
      resultQ     <= '0;
      overflowQ   <= 1'b0;
      timeoutErrQ <= 1'b0;
    end else begin
      sync1Q <= bus.sigIn;
      sync2Q <= sync1Q;
      sync3Q <= sync2Q;
      case (stateQ)
        StIdle: begin
          if (bus.start) begin
            waitCntQ    <= '0;
            overflowQ   <= 1'b0;
            timeoutErrQ <= 1'b0;
          end
        end
        StSettle: begin
          if (bus.relaxIn) begin
            gateCntQ <= '0;
            edgeCntQ <= '0;
          end else if (waitDone) begin
            timeoutErrQ <= 1'b1;
          end else begin
            waitCntQ <= waitCntQ + 32'd1;
          end
        end
        StGate: begin
          gateCntQ <= gateCntQ + 32'd1;
          edgeCntQ <= edgeCntNext;
          if (satHit) overflowQ <= 1'b1;
          // Capture the updated count so an edge in the final gate cycle is included.
          if (gateDone) resultQ <= edgeCntNext;
        end
        default: ;
      endcase
    end
  end

  assign bus.result     = resultQ;
  assign bus.overflow   = overflowQ;
  assign bus.timeoutErr = timeoutErrQ;

endmodule

// File: tb/tb_freq_gate_sequencer.sv
// Self-checking bench: an 8-bit instance for timing/handshake scenarios and a 4-bit instance
// for saturation, with expected results queued when a measurement is launched.
module tb_freq_gate_sequencer;

  localparam int unsigned GateC    = 100;
  localparam int unsigned TimeoutC = 50;

  typedef struct {
    logic [7:0] res;
    logic       ovf;
  } expT;

  logic sysClk   = 1'b0;
  logic sysRst_n = 1'b0;

  freq_gate_sequencer_if #(.COUNT_W(8)) busA ();
  freq_gate_sequencer_if #(.COUNT_W(4)) busB ();

  freq_gate_sequencer #(
    .GATE_CYCLES(GateC), .TIMEOUT_CYCLES(TimeoutC), .COUNT_W(8)
  ) dutA (
    .sysClk(sysClk), .sysRst_n(sysRst_n), .bus(busA)
  );

  freq_gate_sequencer #(
    .GATE_CYCLES(GateC), .TIMEOUT_CYCLES(TimeoutC), .COUNT_W(4)
  ) dutB (
    .sysClk(sysClk), .sysRst_n(sysRst_n), .bus(busB)
  );

  always #5 sysClk = ~sysClk;

  int  checks = 0;
  int  errors = 0;
  expT expA[$];
  expT expB[$];

  int  sigPeriod  = 6;
  int  sigPhase   = 0;
  int  relaxDelay = -1;
  bit  relaxHold  = 1'b0;
  int  relaxCnt   = 0;
  int  relaxHighCnt = 0;

  initial begin
    busA.start = 1'b0; busA.resultReady = 1'b0; busA.sigIn = 1'b0; busA.relaxIn = 1'b0;
    busB.start = 1'b0; busB.resultReady = 1'b0; busB.sigIn = 1'b0; busB.relaxIn = 1'b1;
  end

  // Measured signal: period sigPeriod cycles, 50% duty; 0 means static low.
  initial forever begin
    @(negedge sysClk);
    if (sigPeriod == 0) begin
      busA.sigIn = 1'b0;
      sigPhase   = 0;
    end else begin
      busA.sigIn = (sigPhase < sigPeriod / 2);
      sigPhase   = (sigPhase + 1) % sigPeriod;
    end
    busB.sigIn = busA.sigIn;
  end

  // Delay generator model: relaxIn rises relaxDelay cycles after relaxEn (never if negative).
  initial forever begin
    @(negedge sysClk);
    if (!busA.relaxEn) begin
      relaxCnt     = 0;
      busA.relaxIn = relaxHold;
    end else if (relaxDelay >= 0) begin
      if (relaxCnt >= relaxDelay) busA.relaxIn = 1'b1;
      else relaxCnt++;
    end
  end

  initial forever begin
    @(negedge sysClk);
    if (busA.relaxEn) relaxHighCnt++;
  end

  task automatic pulse_start_a;
    busA.start = 1'b1;
    @(negedge sysClk);
    busA.start = 1'b0;
  endtask

  task automatic accept_a;
    busA.resultReady = 1'b1;
    @(negedge sysClk);
    busA.resultReady = 1'b0;
  endtask

  task automatic wait_valid_a(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busA.resultValid) begin
        ok = 1'b1;
        break;
      end
      @(negedge sysClk);
    end
  endtask

  task automatic wait_valid_b(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busB.resultValid) begin
        ok = 1'b1;
        break;
      end
      @(negedge sysClk);
    end
  endtask

  task automatic test_reset;
    sigPeriod = 6;
    repeat (10) @(negedge sysClk);
    checks++;
    if ({busA.busy, busA.relaxEn, busA.resultValid, busA.overflow, busA.timeoutErr} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000",
               {busA.busy, busA.relaxEn, busA.resultValid, busA.overflow, busA.timeoutErr});
    end
    checks++;
    if (busA.result !== 8'd0) begin
      errors++; $display("FAIL reset_result got %0d want 0", busA.result);
    end
    checks++;
    if ({busB.busy, busB.resultValid, busB.result} !== 6'b0) begin
      errors++; $display("FAIL reset_b got %b want 0", {busB.busy, busB.resultValid, busB.result});
    end
    sysRst_n = 1'b1;
    repeat (5) @(negedge sysClk);
    checks++;
    if ({busA.busy, busA.relaxEn} !== 2'b00) begin
      errors++; $display("FAIL post_reset_idle got %b want 00", {busA.busy, busA.relaxEn});
    end
  endtask

  // relaxIn held high and sigIn static: checks cycle-exact latency and a zero count.
  task automatic test_latency;
    expT e;
    sigPeriod  = 0;
    relaxHold  = 1'b1;
    relaxDelay = 0;
    repeat (10) @(negedge sysClk);
    expA.push_back('{res: 8'd0, ovf: 1'b0});
    pulse_start_a();
    checks++;
    if (busA.relaxEn !== 1'b1) begin
      errors++; $display("FAIL latency_relaxEn_c1 got %b want 1", busA.relaxEn);
    end
    repeat (100) @(negedge sysClk);
    checks++;
    if (busA.resultValid !== 1'b0) begin
      errors++; $display("FAIL latency_valid_c101 got %b want 0", busA.resultValid);
    end
    @(negedge sysClk);
    checks++;
    if (busA.resultValid !== 1'b1 || busA.relaxEn !== 1'b0) begin
      errors++;
      $display("FAIL latency_valid_c102 got valid=%b relaxEn=%b want 1/0",
               busA.resultValid, busA.relaxEn);
    end
    if (expA.size() > 0) begin
      e = expA.pop_front();
      checks++;
      if (busA.result !== e.res || busA.overflow !== e.ovf) begin
        errors++;
        $display("FAIL latency_result got %0d/%b want %0d/%b", busA.result, busA.overflow,
                 e.res, e.ovf);
      end
    end
    accept_a();
    relaxHold = 1'b0;
    repeat (3) @(negedge sysClk);
  endtask

  task automatic test_nominal;
    expT       e;
    bit        ok;
    bit        held;
    int        base;
    logic [7:0] snap;
    sigPeriod  = 10;
    relaxDelay = 20;
    repeat (10) @(negedge sysClk);
    base = relaxHighCnt;
    expA.push_back('{res: 8'(GateC / 10), ovf: 1'b0});
    pulse_start_a();
    wait_valid_a(400, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL nominal_valid_timeout got 0 want resultValid");
    end
    if (expA.size() > 0) begin
      e = expA.pop_front();
      checks++;
      if (busA.result !== e.res || busA.overflow !== e.ovf || busA.timeoutErr !== 1'b0) begin
        errors++;
        $display("FAIL nominal_result got %0d/%b/%b want %0d/%b/0", busA.result, busA.overflow,
                 busA.timeoutErr, e.res, e.ovf);
      end
    end
    snap = busA.result;
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge sysClk);
      if (busA.resultValid !== 1'b1 || busA.result !== snap || busA.relaxEn !== 1'b0) held = 1'b0;
    end
    checks++;
    if (!held) begin
      errors++; $display("FAIL nominal_hold got unstable want valid/result held, relaxEn 0");
    end
    accept_a();
    checks++;
    if (busA.resultValid !== 1'b0 || busA.relaxEn !== 1'b0 || busA.busy !== 1'b0) begin
      errors++;
      $display("FAIL nominal_drop got valid=%b relaxEn=%b busy=%b want 0/0/0",
               busA.resultValid, busA.relaxEn, busA.busy);
    end
    checks++;
    if (relaxHighCnt - base !== 1 + 20 + int'(GateC)) begin
      errors++;
      $display("FAIL nominal_relaxEn_len got %0d want %0d", relaxHighCnt - base, 21 + GateC);
    end
  endtask

  task automatic test_timeout;
    bit noValid;
    relaxDelay = -1;
    relaxHold  = 1'b0;
    repeat (3) @(negedge sysClk);
    pulse_start_a();
    noValid = 1'b1;
    for (int i = 0; i < 49; i++) begin
      @(negedge sysClk);
      if (busA.resultValid) noValid = 1'b0;
    end
    checks++;
    if (busA.relaxEn !== 1'b1 || busA.timeoutErr !== 1'b0) begin
      errors++;
      $display("FAIL timeout_c50 got relaxEn=%b err=%b want 1/0", busA.relaxEn, busA.timeoutErr);
    end
    @(negedge sysClk);
    checks++;
    if (busA.relaxEn !== 1'b0 || busA.timeoutErr !== 1'b1 || busA.busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_c51 got relaxEn=%b err=%b busy=%b want 0/1/0",
               busA.relaxEn, busA.timeoutErr, busA.busy);
    end
    repeat (10) begin
      @(negedge sysClk);
      if (busA.resultValid) noValid = 1'b0;
    end
    checks++;
    if (!noValid) begin
      errors++; $display("FAIL timeout_no_valid got resultValid=1 want 0");
    end
  endtask

  task automatic test_start_ignored;
    expT e;
    bit  ok;
    bit  quiet;
    int  base;
    sigPeriod  = 10;
    relaxDelay = 20;
    repeat (5) @(negedge sysClk);
    base = relaxHighCnt;
    expA.push_back('{res: 8'(GateC / 10), ovf: 1'b0});
    pulse_start_a();
    checks++;
    if (busA.timeoutErr !== 1'b0) begin
      errors++; $display("FAIL start_clears_timeout got %b want 0", busA.timeoutErr);
    end
    repeat (3) @(negedge sysClk);
    pulse_start_a();
    repeat (45) @(negedge sysClk);
    pulse_start_a();
    wait_valid_a(400, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL ignore_valid_timeout got 0 want resultValid");
    end
    if (expA.size() > 0) begin
      e = expA.pop_front();
      checks++;
      if (busA.result !== e.res) begin
        errors++; $display("FAIL ignore_result got %0d want %0d", busA.result, e.res);
      end
    end
    busA.start       = 1'b1;
    busA.resultReady = 1'b1;
    @(negedge sysClk);
    busA.start       = 1'b0;
    busA.resultReady = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (busA.busy || busA.relaxEn || busA.resultValid) quiet = 1'b0;
      @(negedge sysClk);
    end
    checks++;
    if (!quiet) begin
      errors++; $display("FAIL ignore_start_at_done got busy/relaxEn activity want idle");
    end
    checks++;
    if (relaxHighCnt - base !== 1 + 20 + int'(GateC)) begin
      errors++;
      $display("FAIL ignore_relaxEn_len got %0d want %0d", relaxHighCnt - base, 21 + GateC);
    end
  endtask

  task automatic test_overflow;
    expT e;
    bit  ok;
    int  edges;
    for (int run = 0; run < 2; run++) begin
      sigPeriod = (run == 0) ? 4 : 0;
      repeat (10) @(negedge sysClk);
      edges = (run == 0) ? int'(GateC) / 4 : 0;
      expB.push_back('{res: (edges > 15) ? 8'd15 : 8'(edges), ovf: (edges > 15)});
      busB.start = 1'b1;
      @(negedge sysClk);
      busB.start = 1'b0;
      wait_valid_b(300, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL overflow_valid_timeout run %0d got 0 want resultValid", run);
      end
      if (expB.size() > 0) begin
        e = expB.pop_front();
        checks++;
        if (busB.result !== e.res[3:0] || busB.overflow !== e.ovf) begin
          errors++;
          $display("FAIL overflow_result run %0d got %0d/%b want %0d/%b", run, busB.result,
                   busB.overflow, e.res[3:0], e.ovf);
        end
      end
      busB.resultReady = 1'b1;
      @(negedge sysClk);
      busB.resultReady = 1'b0;
    end
  endtask

  task automatic test_reset_mid_gate;
    expT e;
    bit  ok;
    sigPeriod  = 10;
    relaxDelay = 20;
    repeat (5) @(negedge sysClk);
    pulse_start_a();
    repeat (61) @(negedge sysClk);
    checks++;
    if (busA.relaxEn !== 1'b1 || busA.busy !== 1'b1) begin
      errors++; $display("FAIL midgate_pre got relaxEn=%b busy=%b want 1/1", busA.relaxEn, busA.busy);
    end
    sysRst_n = 1'b0;
    #1;
    checks++;
    if ({busA.busy, busA.relaxEn, busA.resultValid, busA.overflow, busA.timeoutErr} !== 5'b0 ||
        busA.result !== 8'd0) begin
      errors++;
      $display("FAIL midgate_async_reset got %b/%0d want 00000/0",
               {busA.busy, busA.relaxEn, busA.resultValid, busA.overflow, busA.timeoutErr},
               busA.result);
    end
    repeat (3) @(negedge sysClk);
    sysRst_n = 1'b1;
    repeat (3) @(negedge sysClk);
    expA.push_back('{res: 8'(GateC / 10), ovf: 1'b0});
    pulse_start_a();
    wait_valid_a(400, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL midgate_valid_timeout got 0 want resultValid");
    end
    if (expA.size() > 0) begin
      e = expA.pop_front();
      checks++;
      if (busA.result !== e.res || busA.overflow !== e.ovf) begin
        errors++;
        $display("FAIL midgate_result got %0d/%b want %0d/%b", busA.result, busA.overflow,
                 e.res, e.ovf);
      end
    end
    accept_a();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_nominal();
    test_timeout();
    test_start_ignored();
    test_overflow();
    test_reset_mid_gate();
    checks++;
    if (expA.size() != 0 || expB.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d/%0d want 0/0", expA.size(), expB.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "bench time limit");
  end

endmodule
